// File: rtl/exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exec_sequencer                                                             |
// | Stalls pico-MIPS commit for LD/ST handshakes and multi-cycle multiplies,   |
// | gating register write to the commit cycle. Optional: IO_TIMEOUT_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module exec_sequencer #(
  parameter int MULT_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic n_reset,
  input  logic read_in,
  input  logic write_out,
  input  logic reg_write,
  input  logic mult_op,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic pc_en,
  output logic reg_we,
  output logic busy,
  output logic timeout_err
);

  localparam int c_CNT_MAX = (MULT_CYCLES > TIMEOUT) ? MULT_CYCLES : TIMEOUT;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CW-1:0] c_MULT_LOAD = c_CW'(MULT_CYCLES - 1);
`ifdef IO_TIMEOUT_EN
  localparam logic [c_CW-1:0] c_TO_LOAD   = c_CW'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_EXEC     = 2'd0,
    S_WAIT_IN  = 2'd1,
    S_WAIT_OUT = 2'd2,
    S_MULT     = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_next_cnt;
  logic            w_in_ready;
  logic            w_pc_en;
  logic            w_reg_we;
`ifdef IO_TIMEOUT_EN
  logic            w_set_err;
  logic            r_timeout_err;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_in_ready   = 1'b0;
    w_pc_en      = 1'b0;
    w_reg_we     = 1'b0;
`ifdef IO_TIMEOUT_EN
    w_set_err    = 1'b0;
`endif
    case (r_state)
      S_EXEC: begin
        if (read_in) begin
          if (in_valid) begin
            w_in_ready = 1'b1;
            w_reg_we   = 1'b1;
            w_pc_en    = 1'b1;
          end else begin
            w_next_state = S_WAIT_IN;
`ifdef IO_TIMEOUT_EN
            w_next_cnt   = c_TO_LOAD;
`endif
          end
        end else if (write_out) begin
          w_next_state = S_WAIT_OUT;
`ifdef IO_TIMEOUT_EN
          w_next_cnt   = c_TO_LOAD;
`endif
        end else if (mult_op) begin
          w_next_state = S_MULT;
          w_next_cnt   = c_MULT_LOAD;
        end else begin
          w_pc_en  = 1'b1;
          w_reg_we = reg_write;
        end
      end
      S_WAIT_IN: begin
        // A handshake in the expiry cycle still commits normally.
        if (in_valid) begin
          w_in_ready   = 1'b1;
          w_reg_we     = 1'b1;
          w_pc_en      = 1'b1;
          w_next_state = S_EXEC;
        end
`ifdef IO_TIMEOUT_EN
        else if (r_cnt == '0) begin
          w_pc_en      = 1'b1;
          w_set_err    = 1'b1;
          w_next_state = S_EXEC;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
`endif
      end
      S_WAIT_OUT: begin
        if (out_ready) begin
          w_pc_en      = 1'b1;
          w_next_state = S_EXEC;
        end
`ifdef IO_TIMEOUT_EN
        else if (r_cnt == '0) begin
          w_pc_en      = 1'b1;
          w_set_err    = 1'b1;
          w_next_state = S_EXEC;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
`endif
      end
      S_MULT: begin
        if (r_cnt == '0) begin
          w_reg_we     = reg_write;
          w_pc_en      = 1'b1;
          w_next_state = S_EXEC;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      default: w_next_state = S_EXEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= S_EXEC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

`ifdef IO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_set_err) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = n_reset & r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  // Every output is forced low in any cycle where reset is asserted.
  assign in_ready  = n_reset & w_in_ready;
  assign pc_en     = n_reset & w_pc_en;
  assign reg_we    = n_reset & w_reg_we;
  assign out_valid = n_reset & (r_state == S_WAIT_OUT);
  assign busy      = n_reset & (r_state != S_EXEC);

endmodule
`default_nettype wire
